hex_display_ctrl: RTL and testbench

//  Register-mapped controller that owns the eight 7-segment digits. It arbitrates two

---
 rtl/hex_display_ctrl.sv | 136 +++++++++++++
 tb/tb_hex_display_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// Register-mapped controller for eight 7-segment digits: round-robin arbitration
// of CPU and debug ports onto digit/blank/blink/control registers plus a blink timer.
module hex_display_ctrl #(
    parameter int unsigned BLINK_DIV = 12_500_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [1:0]  cpu_addr_i,
    input  logic [3:0]  cpu_be_i,
    input  logic [31:0] cpu_wdata_i,
    output logic        cpu_gnt_o,
    output logic        cpu_rvalid_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [1:0]  dbg_addr_i,
    input  logic [3:0]  dbg_be_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_gnt_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] digits_o,
    output logic [7:0]  blank_o
);

    localparam int unsigned CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] WRAP = CW'(BLINK_DIV - 1);

    typedef enum logic {
        OWN_CPU,
        OWN_DBG
    } owner_e;

    owner_e        last_q;
    logic [31:0]   digits_q;
    logic [7:0]    blank_q;
    logic [7:0]    blink_q;
    logic          enable_q;
    logic          phase_q;
    logic [CW-1:0] cnt_q;
    logic          cpu_rvalid_q;
    logic          dbg_rvalid_q;
    logic [31:0]   rdata_q;

    logic          acc;
    logic          sel_we;
    logic [1:0]    sel_addr;
    logic [3:0]    sel_be;
    logic [31:0]   sel_wdata;
    logic [31:0]   rd_val;
    logic          restart;

    // Grants are combinational so a lone requester is accepted in its request cycle.
    always_comb begin
        cpu_gnt_o = !rst_i && cpu_req_i && (!dbg_req_i || last_q == OWN_DBG);
        dbg_gnt_o = !rst_i && dbg_req_i && (!cpu_req_i || last_q == OWN_CPU);
    end

    always_comb begin
        acc       = cpu_gnt_o || dbg_gnt_o;
        sel_we    = dbg_gnt_o ? dbg_we_i    : cpu_we_i;
        sel_addr  = dbg_gnt_o ? dbg_addr_i  : cpu_addr_i;
        sel_be    = dbg_gnt_o ? dbg_be_i    : cpu_be_i;
        sel_wdata = dbg_gnt_o ? dbg_wdata_i : cpu_wdata_i;
        restart   = acc && sel_we && sel_addr == 2'd3 && sel_be[0] && sel_wdata[1];
    end

    always_comb begin
        rd_val = '0;
        case (sel_addr)
            2'd0: rd_val = digits_q;
            2'd1: rd_val = {24'd0, blank_q};
            2'd2: rd_val = {24'd0, blink_q};
            2'd3: rd_val = {29'd0, phase_q, 1'b0, enable_q};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q       <= OWN_DBG;
            digits_q     <= '0;
            blank_q      <= 8'hFC;
            blink_q      <= '0;
            enable_q     <= 1'b1;
            phase_q      <= 1'b0;
            cnt_q        <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            cpu_rvalid_q <= cpu_gnt_o;
            dbg_rvalid_q <= dbg_gnt_o;
            rdata_q      <= (acc && !sel_we) ? rd_val : '0;

            if (acc) begin
                last_q <= dbg_gnt_o ? OWN_DBG : OWN_CPU;
            end

            if (acc && sel_we) begin
                case (sel_addr)
                    2'd0: begin
                        for (int unsigned b = 0; b < 4; b++) begin
                            if (sel_be[b]) begin
                                digits_q[b*8 +: 8] <= sel_wdata[b*8 +: 8];
                            end
                        end
                    end
                    2'd1: if (sel_be[0]) blank_q <= sel_wdata[7:0];
                    2'd2: if (sel_be[0]) blink_q <= sel_wdata[7:0];
                    2'd3: if (sel_be[0]) enable_q <= sel_wdata[0];
                    default: ;
                endcase
            end

            // RESTART takes priority over a coincident wrap.
            if (restart) begin
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else if (cnt_q == WRAP) begin
                cnt_q   <= '0;
                phase_q <= !phase_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign cpu_rvalid_o = cpu_rvalid_q;
    assign dbg_rvalid_o = dbg_rvalid_q;
    assign rdata_o      = rdata_q;
    assign digits_o     = digits_q;
    assign blank_o      = enable_q ? (blank_q | (blink_q & {8{phase_q}})) : 8'hFF;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: register access, arbitration, blink timing
// and asynchronous reset, checked with immediate assertions.
module tb_hex_display_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i;
    logic [1:0]  cpu_addr_i, dbg_addr_i;
    logic [3:0]  cpu_be_i, dbg_be_i;
    logic [31:0] cpu_wdata_i, dbg_wdata_i;
    logic        cpu_gnt_o, cpu_rvalid_o, dbg_gnt_o, dbg_rvalid_o;
    logic [31:0] rdata_o, digits_o;
    logic [7:0]  blank_o;

    int vectors = 0;
    int miscompares = 0;

    hex_display_ctrl #(.BLINK_DIV(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_be_i(cpu_be_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_be_i(dbg_be_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o),
        .rdata_o(rdata_o), .digits_o(digits_o), .blank_o(blank_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts 1 time unit after a rising edge; returns 1 time unit after the commit edge.
    task automatic access(input bit dbg, input bit we, input logic [1:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input string tag);
        if (dbg) begin
            dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = addr; dbg_be_i = be; dbg_wdata_i = wd;
        end else begin
            cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_be_i = be; cpu_wdata_i = wd;
        end
        #1;
        chk({tag, " gnt"}, 32'(dbg ? dbg_gnt_o : cpu_gnt_o), 32'd1);
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
        dbg_req_i = 1'b0;
        chk({tag, " rvalid"}, 32'(dbg ? dbg_rvalid_o : cpu_rvalid_o), 32'd1);
        chk({tag, " rdata"}, rdata_o, exp_rd);
    endtask

    logic [31:0] cpu_vals [3];
    logic [31:0] dbg_vals [2];
    logic [31:0] exp_dig  [5];
    int ci, di;
    bit exp_cpu;

    initial begin
        rst_i = 1'b1;
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_be_i = 0; cpu_wdata_i = 0;
        dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_be_i = 0; dbg_wdata_i = 0;
        cpu_vals[0] = 32'h11111111; cpu_vals[1] = 32'h33333333; cpu_vals[2] = 32'h55555555;
        dbg_vals[0] = 32'h22222222; dbg_vals[1] = 32'h44444444;
        exp_dig[0] = 32'h11111111; exp_dig[1] = 32'h22222222; exp_dig[2] = 32'h33333333;
        exp_dig[3] = 32'h44444444; exp_dig[4] = 32'h55555555;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // reset state
        chk("rst digits", digits_o, 32'h0);
        chk("rst blank", 32'(blank_o), 32'hFC);
        chk("rst rdata", rdata_o, 32'h0);
        chk("rst rvalid", 32'({cpu_rvalid_o, dbg_rvalid_o}), 32'h0);

        // 1: read BLANK
        access(0, 0, 2'd1, 4'h0, 32'h0, 32'h000000FC, "t1 rd blank");

        // 2: byte-enable masked DIGITS writes
        access(0, 1, 2'd0, 4'b0011, 32'h1234ABCD, 32'h0, "t2 wr lo");
        chk("t2 digits lo", digits_o, 32'h0000ABCD);
        access(0, 1, 2'd0, 4'b1100, 32'h1234ABCD, 32'h0, "t2 wr hi");
        chk("t2 digits hi", digits_o, 32'h1234ABCD);
        access(0, 0, 2'd0, 4'h0, 32'h0, 32'h1234ABCD, "t2 rd digits");

        // 3: DBG access first, so the following conflict goes to the CPU
        access(1, 0, 2'd2, 4'h0, 32'h0, 32'h0, "t3 dbg rd blink");
        cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 0; cpu_be_i = 4'hF; cpu_wdata_i = cpu_vals[0];
        dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 0; dbg_be_i = 4'hF; dbg_wdata_i = dbg_vals[0];
        ci = 0; di = 0;
        for (int i = 0; i < 5; i++) begin
            exp_cpu = (i % 2 == 0);
            #1;
            chk("t3 cpu gnt", 32'(cpu_gnt_o), 32'(exp_cpu));
            chk("t3 dbg gnt", 32'(dbg_gnt_o), 32'(!exp_cpu));
            @(posedge clk_i); #1;
            chk("t3 cpu rvalid", 32'(cpu_rvalid_o), 32'(exp_cpu));
            chk("t3 dbg rvalid", 32'(dbg_rvalid_o), 32'(!exp_cpu));
            chk("t3 digits", digits_o, exp_dig[i]);
            if (exp_cpu) begin
                ci++;
                if (ci < 3) cpu_wdata_i = cpu_vals[ci]; else cpu_req_i = 0;
            end else begin
                di++;
                if (di < 2) dbg_wdata_i = dbg_vals[di]; else dbg_req_i = 0;
            end
        end

        // 4: blink timing with BLINK_DIV=4
        access(0, 1, 2'd1, 4'h1, 32'h0, 32'h0, "t4 wr blank");
        access(0, 1, 2'd2, 4'h1, 32'h01, 32'h0, "t4 wr blink");
        access(0, 1, 2'd3, 4'h1, 32'h03, 32'h0, "t4 restart");
        chk("t4 blank k0", 32'(blank_o), 32'h00);
        for (int k = 1; k < 12; k++) begin
            @(posedge clk_i); #1;
            chk("t4 blink", 32'(blank_o), 32'((k / 4) % 2));
        end
        // counter now at its wrap value: restart must beat the toggle
        access(1, 1, 2'd3, 4'h1, 32'h03, 32'h0, "t4 restart on wrap");
        chk("t4 wrap restart", 32'(blank_o), 32'h00);
        for (int k = 1; k < 5; k++) begin
            @(posedge clk_i); #1;
            chk("t4 after restart", 32'(blank_o), (k == 4) ? 32'h01 : 32'h00);
        end

        // 5: disable forces all digits dark; PHASE is 1 at this point
        access(0, 1, 2'd3, 4'h1, 32'h0, 32'h0, "t5 wr ctrl");
        chk("t5 blank off", 32'(blank_o), 32'hFF);
        access(0, 0, 2'd3, 4'h0, 32'h0, 32'h00000004, "t5 rd ctrl");
        chk("t5 blank still off", 32'(blank_o), 32'hFF);

        // 6: async reset between DBG grant and its rvalid
        dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 2'd0; dbg_be_i = 0;
        #1;
        chk("t6 dbg gnt", 32'(dbg_gnt_o), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        chk("t6 async digits", digits_o, 32'h0);
        chk("t6 async blank", 32'(blank_o), 32'hFC);
        chk("t6 gnt in reset", 32'(dbg_gnt_o), 32'd0);
        dbg_req_i = 0;
        @(posedge clk_i); #1;
        chk("t6 no rvalid", 32'(dbg_rvalid_o), 32'd0);
        chk("t6 rdata", rdata_o, 32'h0);
        rst_i = 1'b0;
        // first conflict after reset goes to the CPU
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 2'd3;
        dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 2'd1;
        #1;
        chk("t6 cpu first", 32'({cpu_gnt_o, dbg_gnt_o}), 32'b10);
        @(posedge clk_i); #1;
        cpu_req_i = 0;
        chk("t6 rd ctrl", rdata_o, 32'h00000001);
        chk("t6 dbg granted", 32'({cpu_gnt_o, dbg_gnt_o}), 32'b01);
        @(posedge clk_i); #1;
        dbg_req_i = 0;
        chk("t6 dbg rvalid", 32'(dbg_rvalid_o), 32'd1);
        chk("t6 rd blank", rdata_o, 32'h000000FC);
        access(1, 0, 2'd0, 4'h0, 32'h0, 32'h0, "t6 rd digits");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
